muldiv_seq: RTL and testbench

- Iterative HI/LO multiply/divide sequencer for the pipelined MIPS core (mult, multu, div, divu, mthi, mtlo, mfhi, mflo).
- Owns no adder: drives a shared 32-bit add/sub ALU port (op 3'b000 add, 3'b001 sub) once per cycle.
- Implements shift-add multiply and restoring divide, holding architectural HI/LO.
- Raises busy so the hazard unit stalls HI/LO consumers.

---
 rtl/muldiv_seq.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide sequencer sharing an external 32-bit add/sub ALU.
// Latency: 32 cycles when start is accepted until commit, or 36 for signed ops (only built with MULDIV_SIGNED_EN).
// No backpressure: busy stalls HI/LO consumers, and start and mthi/mtlo are ignored while busy.
module muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, RUN, FIX_LO, FIX_HI} state_t;
  logic is_signed, neg_q, neg_r, lo_zero;
`else
  typedef enum logic [2:0] {IDLE, RUN} state_t;
  logic unused_op0;
  assign unused_op0 = op[0];
`endif

  state_t      state;
  logic        is_div;
  logic [31:0] acc, q, m;
  logic [5:0]  cnt;

  // Divide step: t = {acc, q[31]}, and its 33rd bit is acc[31].
  logic [31:0] t_lo;
  logic        ge, carry, last;
  logic [31:0] run_acc, run_q;

  assign t_lo  = {acc[30:0], q[31]};
  assign ge    = acc[31] | (t_lo >= m);
  assign carry = (alu_result < acc);
  assign last  = (cnt == 6'(ITER - 1));

  always_comb begin
    if (is_div) begin
      run_acc = ge ? alu_result : t_lo;
      run_q   = {q[30:0], ge};
    end else begin
      run_acc = {carry, alu_result[31:1]};
      run_q   = {alu_result[0], q[31:1]};
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (state)
      RUN: begin
        if (is_div) begin
          alu_a  = t_lo;
          alu_b  = m;
          alu_op = ALU_SUB;
        end else begin
          alu_a = acc;
          alu_b = q[0] ? m : 32'd0;
        end
      end
`ifdef MULDIV_SIGNED_EN
      ABS_A: begin
        alu_b  = q;
        alu_op = ALU_SUB;
      end
      ABS_B: begin
        alu_b  = m;
        alu_op = ALU_SUB;
      end
      FIX_LO: begin
        if (neg_q) begin
          alu_b  = q;
          alu_op = ALU_SUB;
        end else begin
          alu_a = q;
        end
      end
      FIX_HI: begin
        if (is_div && neg_r) begin
          alu_b  = acc;
          alu_op = ALU_SUB;
        end else if (!is_div && neg_q) begin
          // Two's-complement negation of the 64-bit product: carry into HI only when LO was zero.
          alu_a = ~acc;
          alu_b = {31'b0, lo_zero};
        end else begin
          alu_a = acc;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      cnt    <= '0;
`ifdef MULDIV_SIGNED_EN
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      lo_zero   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            is_div <= op[1];
            q      <= op[1] ? rs : rt;
            m      <= op[1] ? rt : rs;
            acc    <= '0;
            cnt    <= '0;
`ifdef MULDIV_SIGNED_EN
            is_signed <= op[0];
            state     <= op[0] ? ABS_A : RUN;
`else
            state <= RUN;
`endif
          end else begin
            if (hi_we) hi <= mt_data;
            if (lo_we) lo <= mt_data;
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          acc <= run_acc;
          q   <= run_q;
          if (last) begin
`ifdef MULDIV_SIGNED_EN
            if (is_signed) begin
              state <= FIX_LO;
            end else begin
              hi    <= run_acc;
              lo    <= run_q;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
`else
            hi    <= run_acc;
            lo    <= run_q;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`endif
          end
        end
`ifdef MULDIV_SIGNED_EN
        ABS_A: begin
          if (q[31]) q <= alu_result;
          neg_q <= q[31] ^ m[31];
          neg_r <= is_div & q[31];
          state <= ABS_B;
        end
        ABS_B: begin
          if (m[31]) m <= alu_result;
          state <= RUN;
        end
        FIX_LO: begin
          q       <= alu_result;
          lo_zero <= (q == 32'd0);
          state   <= FIX_HI;
        end
        FIX_HI: begin
          hi    <= alu_result;
          lo    <= q;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random ops checked against 64-bit arithmetic reference.
module tb_muldiv_seq;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0, rt = '0, mt_data = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Shared ALU model.
  assign alu_result = (alu_op == 3'b001) ? alu_a - alu_b : alu_a + alu_b;

  muldiv_seq #(.ITER(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from plain arithmetic on the operands.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit          sgn;
    longint      sa, sb, sq, sr;
    logic [63:0] r;
    sgn = SIGNED && o[0];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    if (!o[1]) begin
      if (sgn) r = 64'(sa * sb);
      else     r = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      // Zero divisor: all-ones magnitude quotient, remainder is the dividend; signs then applied.
      r = {a, (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF};
    end else if (sgn) begin
      sq = sa / sb;
      sr = sa % sb;
      r  = {sr[31:0], sq[31:0]};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return (SIGNED && o[0]) ? 36 : 32;
  endfunction

  // Launch at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit poke, input bit mt_with_start);
    logic [31:0] hi0, lo0;
    logic [63:0] exp;
    int          lat;
    bit          held_bad, done_bad;
    hi0 = hi; lo0 = lo;
    exp = model(o, a, b);
    lat = 0; held_bad = 0; done_bad = 0;
    start = 1'b1; op = o; rs = a; rt = b;
    hi_we = mt_with_start; mt_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; rs = $urandom; rt = $urandom;
    while (busy === 1'b1 && lat < 100) begin
      lat++;
      if (done !== 1'b0) done_bad = 1;
      if (hi !== hi0 || lo !== lo0) held_bad = 1;
      if (poke && lat == 10) begin
        start = 1'b1; op = 2'b10; rs = 32'd1; rt = 32'd1; hi_we = 1'b1; mt_data = 32'h55;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(o)));
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_held"}, {30'd0, held_bad, done_bad}, 32'd0);
    chk({tag, "_hi"}, hi, exp[63:32]);
    chk({tag, "_lo"}, lo, exp[31:0]);
  endtask

  initial begin
    logic [63:0] e;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rs = 32'h1234_5678; rt = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("idle_alu_a", alu_a, 32'd0);
    chk("idle_alu_b", alu_b, 32'd0);
    chk("idle_alu_op", {29'd0, alu_op}, 32'd0);

    // multu of all-ones, checked against literal values too
    run_op("multu_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("multu_ff_hi_lit", hi, 32'hFFFF_FFFE);
    chk("multu_ff_lo_lit", lo, 32'h0000_0001);
    @(negedge clk);
    chk("done_drops", {31'd0, done}, 32'd0);
    chk("idle_alu_a2", alu_a, 32'd0);

    run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0);
    if (SIGNED) begin
      chk("mult_m3x5_hi_lit", hi, 32'hFFFF_FFFF);
      chk("mult_m3x5_lo_lit", lo, 32'hFFFF_FFF1);
    end
    run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("mult_min2", 2'b01, 32'h8000_0000, 32'd2, 0, 0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("divu_z", 2'b10, 32'd100, 32'd0, 0, 0);
    chk("divu_z_lo_lit", lo, 32'hFFFF_FFFF);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0, 0);
    chk("divu_100_7_hi_lit", hi, 32'd2);
    chk("divu_100_7_lo_lit", lo, 32'd14);
    run_op("div_z", 2'b11, 32'hFFFF_FF00, 32'd0, 0, 0);

    // mtlo/mthi in IDLE
    @(negedge clk);
    lo_we = 1'b1; mt_data = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", lo, 32'h1234);
    e = {hi, 32'd0};
    hi_we = 1'b1; mt_data = 32'hCAFE_0001;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'hCAFE_0001);
    chk("mthi_lo_kept", lo, 32'h1234);

    // start with mthi in the same cycle, then mthi/start while busy
    run_op("start_mt", 2'b00, 32'd7, 32'd6, 0, 1);
    run_op("busy_poke", 2'b10, 32'hFFFF_0000, 32'd13, 1, 0);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs = 32'hFFFF_FFFF; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) e[0] = 1'b1;
    end
    chk("abort_no_done", {31'd0, e[0]}, 32'd0);
    run_op("divu_9_3", 2'b10, 32'd9, 32'd3, 0, 0);
    chk("divu_9_3_lo_lit", lo, 32'd3);

    // random ops, back to back
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i % 5 == 0) ra = {ra[31], 31'd0};
      run_op("rand", ro, ra, rb, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
